// File: rtl/operand_pkg.sv
// rtl/operand_pkg.sv - shared slot states, operand indices and default frame timing
package operand_pkg;

    typedef enum logic [1:0] {
        SHOW     = 2'd0,
        BLINK    = 2'd1,
        PENDING  = 2'd2,
        COOLDOWN = 2'd3
    } op_state_t;

    localparam int OP_PLUS  = 0;
    localparam int OP_MINUS = 1;

    localparam int DEF_NUM_OPERANDS    = 2;
    localparam int DEF_LIFETIME_FRAMES = 600;
    localparam int DEF_BLINK_FRAMES    = 120;
    localparam int DEF_BLINK_PERIOD    = 8;
    localparam int DEF_RESPAWN_FRAMES  = 180;
    localparam int DEF_CNT_W           = 10;

endpackage

// File: rtl/operand_slot_fsm.sv
// rtl/operand_slot_fsm.sv - per-slot visibility FSM: show, blink, pending hand-off, cooldown
module operand_slot_fsm
    import operand_pkg::*;
#(
    parameter int LIFETIME_FRAMES = DEF_LIFETIME_FRAMES,
    parameter int BLINK_FRAMES    = DEF_BLINK_FRAMES,
    parameter int BLINK_PERIOD    = DEF_BLINK_PERIOD,
    parameter int RESPAWN_FRAMES  = DEF_RESPAWN_FRAMES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_tick,
    input  logic i_hit,
    input  logic i_grant,
    output logic o_show,
    output logic o_pending
);

    localparam int               BLINK_BIT    = $clog2(BLINK_PERIOD);
    localparam logic [CNT_W-1:0] BLINK_START  = CNT_W'(LIFETIME_FRAMES - BLINK_FRAMES);
    localparam logic [CNT_W-1:0] LIFE_LAST    = CNT_W'(LIFETIME_FRAMES - 1);
    localparam logic [CNT_W-1:0] RESPAWN_LAST = CNT_W'(RESPAWN_FRAMES - 1);

    op_state_t        r_state;
    op_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign o_pending = (r_state == PENDING);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= SHOW;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A hit always beats a same-cycle expiry tick, so the hit test comes first.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_show      = 1'b0;
        case (r_state)
            SHOW: begin
                o_show = 1'b1;
                if (i_hit) begin
                    w_state_nxt = PENDING;
                end else if (i_tick) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == BLINK_START) begin
                        w_state_nxt = BLINK;
                    end
                end
            end
            BLINK: begin
                o_show = ~r_cnt[BLINK_BIT];
                if (i_hit) begin
                    w_state_nxt = PENDING;
                end else if (i_tick) begin
                    if (r_cnt == LIFE_LAST) begin
                        w_state_nxt = COOLDOWN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            PENDING: begin
                if (i_grant) begin
                    w_state_nxt = COOLDOWN;
                    w_cnt_nxt   = '0;
                end
            end
            COOLDOWN: begin
                if (i_tick) begin
                    if (r_cnt == RESPAWN_LAST) begin
                        w_state_nxt = SHOW;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            default: begin
                w_state_nxt = SHOW;
                w_cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/operand_spawn_controller.sv
// rtl/operand_spawn_controller.sv - operand slot sequencing with round-robin hand-off to the score unit
module operand_spawn_controller
    import operand_pkg::*;
#(
    parameter int NUM_OPERANDS    = DEF_NUM_OPERANDS,
    parameter int LIFETIME_FRAMES = DEF_LIFETIME_FRAMES,
    parameter int BLINK_FRAMES    = DEF_BLINK_FRAMES,
    parameter int BLINK_PERIOD    = DEF_BLINK_PERIOD,
    parameter int RESPAWN_FRAMES  = DEF_RESPAWN_FRAMES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_start_of_frame,
    input  logic                            i_game_enable,
    input  logic [NUM_OPERANDS-1:0]         i_single_hit,
    output logic [NUM_OPERANDS-1:0]         o_show_operand,
    output logic                            o_apply_valid,
    output logic [$clog2(NUM_OPERANDS)-1:0] o_apply_idx,
    input  logic                            i_apply_ready,
    output logic [7:0]                      o_collected_cnt
);

    localparam int             IDX_W = $clog2(NUM_OPERANDS);
    localparam logic [IDX_W:0] N_W   = (IDX_W+1)'(NUM_OPERANDS);

    logic                    w_tick;
    logic                    w_xfer;
    logic [NUM_OPERANDS-1:0] w_pending;
    logic [NUM_OPERANDS-1:0] w_grant;
    logic [NUM_OPERANDS-1:0] w_pend_rot;
    logic                    w_found;
    logic [IDX_W:0]          w_sum;
    logic [IDX_W-1:0]        w_pick;
    logic [IDX_W-1:0]        w_idx_inc;

    logic                    r_apply_valid;
    logic [IDX_W-1:0]        r_apply_idx;
    logic [IDX_W-1:0]        r_rr_ptr;
    logic [7:0]              r_collected_cnt;

    assign w_tick  = i_start_of_frame & i_game_enable;
    assign w_xfer  = r_apply_valid & i_apply_ready;
    assign w_grant = w_xfer ? (NUM_OPERANDS'(1) << r_apply_idx) : '0;

    for (genvar g = 0; g < NUM_OPERANDS; g++) begin : g_slot
        operand_slot_fsm #(
            .LIFETIME_FRAMES (LIFETIME_FRAMES),
            .BLINK_FRAMES    (BLINK_FRAMES),
            .BLINK_PERIOD    (BLINK_PERIOD),
            .RESPAWN_FRAMES  (RESPAWN_FRAMES),
            .CNT_W           (CNT_W)
        ) u_slot (
            .i_clk     (i_clk),
            .i_reset   (i_reset),
            .i_tick    (w_tick),
            .i_hit     (i_single_hit[g] & i_game_enable),
            .i_grant   (w_grant[g]),
            .o_show    (o_show_operand[g]),
            .o_pending (w_pending[g])
        );
    end

    // Rotate pending so bit 0 is the RR pointer slot; the first set bit is the winner.
    always_comb begin
        w_pend_rot = NUM_OPERANDS'({w_pending, w_pending} >> r_rr_ptr);
        w_found    = 1'b0;
        w_sum      = '0;
        for (int k = 0; k < NUM_OPERANDS; k++) begin
            if (!w_found && w_pend_rot[k]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            end
        end
        w_pick = (w_sum >= N_W) ? IDX_W'(w_sum - N_W) : IDX_W'(w_sum);
    end

    assign w_idx_inc = (r_apply_idx == IDX_W'(NUM_OPERANDS - 1)) ? '0 : r_apply_idx + IDX_W'(1);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_apply_valid   <= 1'b0;
            r_apply_idx     <= '0;
            r_rr_ptr        <= '0;
            r_collected_cnt <= '0;
        end else if (w_xfer) begin
            r_apply_valid <= 1'b0;
            r_rr_ptr      <= w_idx_inc;
            if (r_collected_cnt != 8'hFF) begin
                r_collected_cnt <= r_collected_cnt + 8'd1;
            end
        end else if (!r_apply_valid && w_found) begin
            r_apply_valid <= 1'b1;
            r_apply_idx   <= w_pick;
        end
    end

    assign o_apply_valid   = r_apply_valid;
    assign o_apply_idx     = r_apply_idx;
    assign o_collected_cnt = r_collected_cnt;

endmodule

// File: tb/tb_operand_spawn_controller.sv
// tb/tb_operand_spawn_controller.sv - scoreboard bench for operand_spawn_controller
module tb_operand_spawn_controller;

    localparam int N       = 2;
    localparam int LIFE    = 600;
    localparam int BLINK   = 120;
    localparam int BPER    = 8;
    localparam int RESPAWN = 180;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sof = 1'b0;
    logic       ge = 1'b0;
    logic [1:0] hit = 2'b00;
    logic       ready = 1'b0;
    logic [1:0] show;
    logic       valid;
    logic [0:0] idx;
    logic [7:0] cnt;

    int total = 0;
    int bad = 0;
    bit mon_en = 1'b0;

    operand_spawn_controller dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_start_of_frame (sof),
        .i_game_enable    (ge),
        .i_single_hit     (hit),
        .o_show_operand   (show),
        .o_apply_valid    (valid),
        .o_apply_idx      (idx),
        .i_apply_ready    (ready),
        .o_collected_cnt  (cnt)
    );

    always #5 clk = ~clk;

    // Reference: 0 = on screen (age counts frames since spawn), 1 = waiting for score unit, 2 = hidden.
    int m_mode[N];
    int m_age[N];
    bit m_valid;
    int m_idx;
    int m_ptr;
    int m_cnt;

    typedef struct {
        int idx;
        int cnt;
    } exp_t;
    exp_t sbq[$];

    function automatic logic [1:0] m_show();
        logic [1:0] v;
        for (int s = 0; s < N; s++) begin
            v[s] = (m_mode[s] == 0) && ((m_age[s] < LIFE - BLINK) || ((m_age[s] / BPER) % 2 == 0));
        end
        return v;
    endfunction

    always @(posedge clk) begin : model
        int grant_slot;
        int offer;
        bit tick;
        if (reset) begin
            for (int s = 0; s < N; s++) begin
                m_mode[s] = 0;
                m_age[s]  = 0;
            end
            m_valid = 1'b0;
            m_idx   = 0;
            m_ptr   = 0;
            m_cnt   = 0;
            sbq.delete();
        end else begin
            tick       = sof && ge;
            grant_slot = (m_valid && ready) ? m_idx : -1;
            offer      = -1;
            if (!m_valid) begin
                for (int k = 0; k < N; k++) begin
                    if (offer < 0 && m_mode[(m_ptr + k) % N] == 1) offer = (m_ptr + k) % N;
                end
            end
            for (int s = 0; s < N; s++) begin
                if (m_mode[s] == 0) begin
                    if (hit[s] && ge) m_mode[s] = 1;
                    else if (tick) begin
                        if (m_age[s] == LIFE - 1) begin
                            m_mode[s] = 2;
                            m_age[s]  = 0;
                        end else m_age[s]++;
                    end
                end else if (m_mode[s] == 1) begin
                    if (grant_slot == s) begin
                        m_mode[s] = 2;
                        m_age[s]  = 0;
                    end
                end else if (tick) begin
                    if (m_age[s] == RESPAWN - 1) begin
                        m_mode[s] = 0;
                        m_age[s]  = 0;
                    end else m_age[s]++;
                end
            end
            if (grant_slot >= 0) begin
                m_valid = 1'b0;
                m_ptr   = (grant_slot + 1) % N;
                if (m_cnt < 255) m_cnt++;
            end else if (offer >= 0) begin
                m_valid = 1'b1;
                m_idx   = offer;
                sbq.push_back('{idx: offer, cnt: m_cnt});
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("show_vec", 32'(show), 32'(m_show()));
            chk("apply_valid", 32'(valid), 32'(m_valid));
            chk("collected_cnt", 32'(cnt), 32'(m_cnt));
            if (valid === 1'b1) begin
                if (sbq.size() == 0) begin
                    chk("offer_expected", 32'(valid), 32'd0);
                end else begin
                    chk("apply_idx", 32'(idx), 32'(sbq[0].idx));
                    if (ready) begin
                        chk("xfer_cnt_before", 32'(cnt), 32'(sbq[0].cnt));
                        void'(sbq.pop_front());
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        hit   = 2'b00;
        sof   = 1'b1;
        ge    = 1'b1;
        cyc(2);
        reset  = 1'b0;
        mon_en = 1'b1;
    endtask

    int fr[8] = '{479, 480, 488, 496, 599, 600, 779, 780};
    int ex[8] = '{1, 1, 0, 1, 1, 0, 0, 1};

    initial begin
        // Free-running lifetime, one frame per cycle.
        ready = 1'b1;
        do_reset();
        chk("rst_show", 32'(show), 32'd3);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_idx", 32'(idx), 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        for (int f = 1; f <= 780; f++) begin
            cyc(1);
            for (int j = 0; j < 8; j++) begin
                if (fr[j] == f) chk($sformatf("life_show_f%0d", f), 32'(show[0]), 32'(ex[j]));
            end
        end

        // Single hit at frame 100.
        do_reset();
        cyc(100);
        hit = 2'b01;
        cyc(1);
        hit = 2'b00;
        chk("hit_show_low", 32'(show[0]), 32'd0);
        chk("hit_valid_early", 32'(valid), 32'd0);
        cyc(1);
        chk("hit_valid", 32'(valid), 32'd1);
        chk("hit_idx", 32'(idx), 32'd0);
        cyc(1);
        chk("hit_cnt", 32'(cnt), 32'd1);
        cyc(179);
        chk("respawn_before", 32'(show[0]), 32'd0);
        cyc(1);
        chk("respawn_after", 32'(show[0]), 32'd1);

        // Simultaneous hits, then wrapped pointer, then pointer at 1.
        do_reset();
        cyc(5);
        hit = 2'b11;
        cyc(1);
        hit = 2'b00;
        cyc(8);
        chk("dual_cnt", 32'(cnt), 32'd2);
        cyc(180);
        hit = 2'b11;
        cyc(1);
        hit = 2'b00;
        cyc(2);
        chk("dual2_first", 32'(idx), 32'd0);
        cyc(186);
        hit = 2'b01;
        cyc(1);
        hit = 2'b00;
        cyc(190);
        hit = 2'b11;
        cyc(1);
        hit = 2'b00;
        cyc(1);
        chk("dual3_first", 32'(idx), 32'd1);
        cyc(8);
        chk("dual3_cnt", 32'(cnt), 32'd7);

        // Back-pressure for 50 cycles with a repeated hit on the waiting slot.
        ready = 1'b0;
        do_reset();
        hit = 2'b01;
        cyc(1);
        hit = 2'b00;
        cyc(10);
        hit = 2'b01;
        cyc(1);
        hit = 2'b00;
        cyc(39);
        chk("bp_valid", 32'(valid), 32'd1);
        chk("bp_idx", 32'(idx), 32'd0);
        ready = 1'b1;
        cyc(1);
        chk("bp_cnt", 32'(cnt), 32'd1);
        cyc(3);
        chk("bp_no_second", 32'(cnt), 32'd1);

        // Freeze for 300 frames at counter 200 with hits held.
        do_reset();
        cyc(200);
        ge  = 1'b0;
        hit = 2'b11;
        cyc(300);
        chk("frz_valid", 32'(valid), 32'd0);
        chk("frz_show", 32'(show), 32'd3);
        ge  = 1'b1;
        hit = 2'b00;
        cyc(399);
        chk("frz_599", 32'(show[0]), 32'd1);
        cyc(1);
        chk("frz_expired", 32'(show[0]), 32'd0);

        // Hit coincident with the final lifetime tick.
        ready = 1'b0;
        do_reset();
        cyc(599);
        hit = 2'b01;
        cyc(1);
        hit = 2'b00;
        chk("edge_show", 32'(show[0]), 32'd0);
        cyc(1);
        chk("edge_pending", 32'(valid), 32'd1);
        chk("edge_idx", 32'(idx), 32'd0);

        // Reset mid-handshake after one transfer has moved the pointer to 1.
        ready = 1'b1;
        do_reset();
        hit = 2'b01;
        cyc(1);
        hit = 2'b00;
        cyc(3);
        ready = 1'b0;
        hit = 2'b10;
        cyc(1);
        hit = 2'b00;
        cyc(2);
        chk("mid_valid", 32'(valid), 32'd1);
        chk("mid_idx", 32'(idx), 32'd1);
        reset = 1'b1;
        cyc(1);
        chk("mid_rst_valid", 32'(valid), 32'd0);
        chk("mid_rst_idx", 32'(idx), 32'd0);
        chk("mid_rst_cnt", 32'(cnt), 32'd0);
        chk("mid_rst_show", 32'(show), 32'd3);
        reset = 1'b0;
        ready = 1'b1;
        hit   = 2'b11;
        cyc(1);
        hit = 2'b00;
        cyc(1);
        chk("mid_rr_reset", 32'(idx), 32'd0);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            reset = ($urandom_range(0, 2999) == 0);
            sof   = ($urandom_range(0, 1) == 0);
            ge    = ($urandom_range(0, 15) != 0);
            hit   = {($urandom_range(0, 31) == 0), ($urandom_range(0, 31) == 0)};
            ready = $urandom_range(0, 1);
            cyc(1);
        end

        // Saturation of the collected counter.
        do_reset();
        ready = 1'b1;
        hit   = 2'b11;
        cyc(24500);
        chk("sat_cnt", 32'(cnt), 32'd255);
        hit = 2'b00;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
